// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises the chute sensors and validates each pulse by its width.
// Accepted coins are queued and emitted as single-cycle codes, each followed by idle cycles.
module coin_acceptor #(
    parameter int MIN_PULSE  = 4,
    parameter int MAX_PULSE  = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sense5,
    input  logic       sense10,
    input  logic       hold,
    output logic [1:0] coin,
    output logic       coin_rejected,
    output logic       fifo_full,
    output logic       busy
);
    localparam int CW = $clog2(MAX_PULSE + 2);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {IDLE, MEASURE, WAIT_REL} state_t;

    logic [1:0]    s5_q, s10_q;
    logic          s5, s10;
    state_t        state_q, state_d;
    logic [1:0]    type_q, type_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rej_q, rej_d;
    logic          push, pop, full;
    logic          lat, oth;

    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   occ_q;
    logic [1:0]    coin_q, coin_d;
    logic [GW-1:0] gap_q, gap_d;

    assign s5  = s5_q[1];
    assign s10 = s10_q[1];
    assign lat = (type_q == 2'b01) ? s5  : s10;
    assign oth = (type_q == 2'b01) ? s10 : s5;
    assign full = (occ_q == (AW+1)'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        rej_d   = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (s5 ^ s10) begin
                    state_d = MEASURE;
                    type_d  = s5 ? 2'b01 : 2'b10;
                    cnt_d   = CW'(1);
                end else if (s5 && s10) begin
                    state_d = WAIT_REL;
                end
            end
            MEASURE: begin
                if (oth) begin
                    state_d = WAIT_REL;
                end else if (lat) begin
                    // Saturate just past the limit; the pulse is already doomed.
                    if (cnt_q >= CW'(MAX_PULSE)) begin
                        cnt_d   = CW'(MAX_PULSE + 1);
                        state_d = WAIT_REL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = IDLE;
                    if (cnt_q >= CW'(MIN_PULSE) && cnt_q <= CW'(MAX_PULSE) && !full)
                        push = 1'b1;
                    else
                        rej_d = 1'b1;
                end
            end
            WAIT_REL: begin
                if (!s5 && !s10) begin
                    rej_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Emitter: gap_q counts the idle cycles owed after each code.
    always_comb begin
        pop    = (gap_q == '0) && (occ_q != '0) && !hold;
        coin_d = pop ? mem_q[rd_q] : 2'b00;
        gap_d  = pop ? GW'(GAP) : ((gap_q != '0) ? gap_q - GW'(1) : gap_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s5_q    <= '0;
            s10_q   <= '0;
            state_q <= IDLE;
            type_q  <= 2'b01;
            cnt_q   <= '0;
            rej_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            occ_q   <= '0;
            coin_q  <= 2'b00;
            gap_q   <= '0;
        end else begin
            s5_q    <= {s5_q[0], sense5};
            s10_q   <= {s10_q[0], sense10};
            state_q <= state_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            rej_q   <= rej_d;
            coin_q  <= coin_d;
            gap_q   <= gap_d;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            occ_q <= occ_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= type_q;
    end

    assign coin          = coin_q;
    assign coin_rejected = rej_q;
    assign fifo_full     = full;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: table of single pulses plus hand-written corner sequences,
// with a scoreboard of expected coin/reject events and the cycle each must appear in.
module tb_coin_acceptor;
    logic       clk = 1'b0, rst = 1'b0, sense5 = 1'b0, sense10 = 1'b0, hold = 1'b0;
    logic [1:0] coin;
    logic       coin_rejected, fifo_full, busy;

    coin_acceptor dut (
        .clk(clk), .rst(rst), .sense5(sense5), .sense10(sense10), .hold(hold),
        .coin(coin), .coin_rejected(coin_rejected), .fifo_full(fifo_full), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [1:0] kind; int cyc; } exp_t;   // kind 1/2 = code, 3 = reject
    typedef struct { bit is10; int width; logic [1:0] kind; } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   n_cmp = 0, n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic observe(input logic [1:0] k, input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s unexpected: got kind %0d at cycle %0d, expected no event", name, k, cyc);
        end else begin
            e = sb.pop_front();
            check({name, " kind"}, int'(k), int'(e.kind));
            check({name, " cycle"}, cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (coin != 2'b00) observe(coin, "coin");
            if (coin_rejected) observe(2'd3, "reject");
        end
    end

    task automatic expect_ev(input logic [1:0] kind, input int at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // Raw pulse of 'width' sampled edges; kind 0 means nothing observable is expected yet.
    // e0 = cyc+1 on release: rejects show at e0+2, accepts (idle emitter) at e0+3.
    task automatic pulse(input bit is10, input int width, input logic [1:0] kind);
        @(negedge clk);
        if (is10) sense10 = 1'b1; else sense5 = 1'b1;
        repeat (width) @(negedge clk);
        sense5  = 1'b0;
        sense10 = 1'b0;
        if (kind == 2'd3)      expect_ev(kind, cyc + 3);
        else if (kind != 2'd0) expect_ev(kind, cyc + 4);
    endtask

    initial begin
        int c0;
        vecs = '{'{1'b0, 10, 2'd1}, '{1'b1, 3, 2'd3}, '{1'b1, 4, 2'd2}, '{1'b1, 64, 2'd2},
                 '{1'b1, 65, 2'd3}, '{1'b0, 4, 2'd1}, '{1'b0, 3, 2'd3}, '{1'b0, 1, 2'd3}};

        repeat (3) @(negedge clk);
        check("reset coin", int'(coin), 0);
        check("reset coin_rejected", int'(coin_rejected), 0);
        check("reset fifo_full", int'(fifo_full), 0);
        check("reset busy", int'(busy), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            pulse(vecs[i].is10, vecs[i].width, vecs[i].kind);
            repeat (8) @(negedge clk);
        end
        check("idle after vectors", int'(busy), 0);

        // 5-chute pulse of 8 edges with the 10 chute high on edges 4..6
        @(negedge clk);
        sense5 = 1'b1;
        repeat (3) @(negedge clk);
        sense10 = 1'b1;
        repeat (3) @(negedge clk);
        sense10 = 1'b0;
        repeat (2) @(negedge clk);
        sense5 = 1'b0;
        expect_ev(2'd3, cyc + 3);
        repeat (8) @(negedge clk);

        // Fill the FIFO under hold, overflow it, then drain
        hold = 1'b1;
        pulse(1'b0, 6, 2'd0);
        pulse(1'b1, 6, 2'd0);
        pulse(1'b0, 6, 2'd0);
        check("fifo_full at 3", int'(fifo_full), 0);
        pulse(1'b1, 6, 2'd0);
        repeat (6) @(negedge clk);
        check("fifo_full at 4", int'(fifo_full), 1);
        pulse(1'b0, 6, 2'd3);
        repeat (6) @(negedge clk);
        check("fifo_full after overflow", int'(fifo_full), 1);
        hold = 1'b0;
        c0 = cyc + 1;
        expect_ev(2'd1, c0);
        expect_ev(2'd2, c0 + 2);
        expect_ev(2'd1, c0 + 4);
        expect_ev(2'd2, c0 + 6);
        @(negedge clk);
        check("fifo_full after first pop", int'(fifo_full), 0);
        repeat (12) @(negedge clk);

        // Reset with two queued coins and a measurement in flight
        hold = 1'b1;
        pulse(1'b0, 6, 2'd0);
        pulse(1'b1, 6, 2'd0);
        @(negedge clk);
        sense5 = 1'b1;
        repeat (4) @(negedge clk);
        check("busy while measuring", int'(busy), 1);
        sense5 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("post-reset coin", int'(coin), 0);
        check("post-reset busy", int'(busy), 0);
        check("post-reset fifo_full", int'(fifo_full), 0);
        check("post-reset coin_rejected", int'(coin_rejected), 0);
        hold = 1'b0;
        repeat (15) @(negedge clk);

        // Sensor held across reset release: only the 3 post-reset edges count
        rst = 1'b0;
        sense5 = 1'b1;
        repeat (3) @(negedge clk);
        check("busy held in reset", int'(busy), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        sense5 = 1'b0;
        expect_ev(2'd3, cyc + 3);
        repeat (10) @(negedge clk);

        check("scoreboard drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
